// File: rtl/card_pkg.sv
// card_pkg: deck constants, card id type and rank-to-value mapping shared by the card dealer.
package card_pkg;
   localparam int NUM_CARDS = 52;
   localparam int RANKS = 13;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   typedef logic [5:0] card_id_t;
   function automatic logic [3:0] rank_to_value(input logic [3:0] rank_idx);
      return rank_idx == 4'd0 ? 4'd1 : rank_idx < 4'd10 ? rank_idx + 4'd1 : 4'd10;
   endfunction
endpackage

// File: rtl/card_picker.sv
// card_picker: first undealt card at or after the candidate, wrapping 51 to 0.
module card_picker
   import card_pkg::*;
(
   input  logic [NUM_CARDS-1:0] dealt_i,
   input  card_id_t             cand_i,
   output card_id_t             card_o,
   output logic                 all_dealt_o
);
   logic [6:0] idx;
   always_comb begin
      card_o = cand_i;
      idx = '0;
      // Descending scan so the smallest offset from the candidate wins; a full deck leaves the candidate.
      for (int i = NUM_CARDS - 1; i >= 0; i--) begin
         idx = 7'(cand_i) + 7'(i);
         idx = idx >= 7'(NUM_CARDS) ? idx - 7'(NUM_CARDS) : idx;
         if (!dealt_i[idx]) card_o = idx[5:0];
      end
      all_dealt_o = &dealt_i;
   end
endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals non-repeating pseudo-random cards from one 52-card deck,
// reshuffling automatically once the deck is exhausted.
module card_dealer
   import card_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          ROM_BASE   = 0,
   parameter int          ROM_STRIDE = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       draw_card,
   output logic [8:0] rom_address,
   output logic [3:0] card_value,
   output logic       card_valid
);
   logic [15:0]          lfsr_q, lfsr_d;
   logic [NUM_CARDS-1:0] dealt_q, dealt_d;
   card_id_t             cand, pick;
   logic                 all_dealt;
   logic [3:0]           rank;
   logic [8:0]           addr_d;

   card_picker u_picker (
      .dealt_i     (dealt_q),
      .cand_i      (cand),
      .card_o      (pick),
      .all_dealt_o (all_dealt)
   );

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);
      cand = lfsr_q[5:0] < 6'(NUM_CARDS) ? lfsr_q[5:0] : lfsr_q[5:0] - 6'(NUM_CARDS);
      // A full deck is cleared before marking, so only the new card remains dealt.
      dealt_d = (all_dealt ? '0 : dealt_q) | ({{(NUM_CARDS-1){1'b0}}, 1'b1} << pick);
      rank = 4'(pick % 6'(RANKS));
      addr_d = 9'(ROM_BASE + int'(pick) * ROM_STRIDE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q      <= LFSR_SEED;
         dealt_q     <= '0;
         rom_address <= '0;
         card_value  <= '0;
         card_valid  <= 1'b0;
      end else begin
         lfsr_q     <= lfsr_d;
         card_valid <= draw_card;
         if (draw_card) begin
            dealt_q     <= dealt_d;
            rom_address <= addr_d;
            card_value  <= rank_to_value(rank);
         end
      end
   end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: table vectors, directed deck/reshuffle/repeat sequences and a
// randomized scoreboard against a deck-level reference model.
module tb_card_dealer;
   logic       clk = 0, reset = 1, draw_card = 0;
   logic [8:0] rom_address;
   logic [3:0] card_value;
   logic       card_valid;
   int tests = 0, fails = 0;

   card_dealer dut (
      .clk         (clk),
      .reset       (reset),
      .draw_card   (draw_card),
      .rom_address (rom_address),
      .card_value  (card_value),
      .card_valid  (card_valid)
   );

   always #5 clk = ~clk;

   int m_lfsr, m_addr, m_val, last_id;
   bit m_valid;
   bit m_dealt[52];
   int vals[13] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10};

   typedef struct {bit r; bit d; int ev; int eval; int eaddr;} vec_t;
   vec_t tv[4];

   task automatic chk(input string n, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic m_deal();
      int cand, id;
      bit all;
      cand = m_lfsr & 63;
      if (cand >= 52) cand -= 52;
      all = 1;
      foreach (m_dealt[i]) if (!m_dealt[i]) all = 0;
      id = cand;
      if (all) foreach (m_dealt[i]) m_dealt[i] = 0;
      else
         for (int off = 0; off < 52; off++)
            if (!m_dealt[(cand + off) % 52]) begin
               id = (cand + off) % 52;
               break;
            end
      m_dealt[id] = 1;
      m_addr = id * 8;
      m_val = vals[id % 13];
      m_valid = 1;
   endtask

   task automatic cycle(input bit r, input bit d);
      reset = r;
      draw_card = d;
      @(posedge clk);
      if (r) begin
         m_lfsr = 16'hACE1;
         foreach (m_dealt[i]) m_dealt[i] = 0;
         m_addr = 0;
         m_val = 0;
         m_valid = 0;
      end else begin
         if (d) m_deal();
         else m_valid = 0;
         m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
      #1;
      chk("valid", int'(card_valid), int'(m_valid));
      chk("value", int'(card_value), m_val);
      chk("addr", int'(rom_address), m_addr);
      last_id = int'(rom_address) / 8;
   endtask

   task automatic chk_legal();
      bit ok;
      ok = rom_address <= 9'd408 && rom_address[2:0] == 3'd0;
      chk("addr_legal", int'(ok), 1);
      if (ok) chk("val_vs_rank", int'(card_value), vals[last_id % 13]);
   endtask

   initial begin
      int ids[5];
      int seen[52];
      int a[10];
      int n, aces, tens, prev, r;
      tv[0] = '{1, 0, 0, 0, 0};
      tv[1] = '{1, 1, 0, 0, 0};
      tv[2] = '{0, 0, 0, 0, 0};
      tv[3] = '{0, 0, 0, 0, 0};
      foreach (tv[i]) begin
         cycle(tv[i].r, tv[i].d);
         chk("tbl_valid", int'(card_valid), tv[i].ev);
         chk("tbl_value", int'(card_value), tv[i].eval);
         chk("tbl_addr", int'(rom_address), tv[i].eaddr);
      end
      for (int k = 0; k < 5; k++) begin
         cycle(0, 1);
         chk("pulse", int'(card_valid), 1);
         chk_legal();
         ids[k] = last_id;
         prev = int'(rom_address);
         for (int j = 0; j < 2; j++) begin
            cycle(0, 0);
            chk("hold", int'(rom_address), prev);
         end
      end
      n = 0;
      foreach (ids[i]) begin
         bit dup = 0;
         for (int j = 0; j < i; j++) if (ids[j] == ids[i]) dup = 1;
         if (!dup) n++;
      end
      chk("distinct5", n, 5);

      cycle(1, 0);
      foreach (seen[i]) seen[i] = 0;
      aces = 0;
      tens = 0;
      for (int k = 0; k < 52; k++) begin
         cycle(0, 1);
         chk_legal();
         if (last_id < 52) seen[last_id]++;
         aces += int'(card_value == 4'd1);
         tens += int'(card_value == 4'd10);
      end
      n = 0;
      foreach (seen[i]) n += int'(seen[i] == 1);
      chk("cover52", n, 52);
      chk("aces", aces, 4);
      chk("tens", tens, 16);

      cycle(0, 1);
      chk("reshuffle_valid", int'(card_valid), 1);
      chk_legal();
      r = last_id;
      foreach (seen[i]) seen[i] = 0;
      n = 0;
      for (int k = 0; k < 51; k++) begin
         cycle(0, 1);
         if (last_id < 52 && last_id != r && seen[last_id] == 0) n++;
         if (last_id < 52) seen[last_id]++;
      end
      chk("post_shuffle", n, 51);

      cycle(1, 0);
      for (int k = 0; k < 10; k++) begin
         cycle(0, 1);
         a[k] = last_id;
      end
      cycle(1, 1);
      chk("draw_in_reset", int'(card_valid), 0);
      for (int k = 0; k < 10; k++) begin
         cycle(0, 1);
         chk("repeat", last_id, a[k]);
      end

      cycle(1, 0);
      for (int k = 0; k < 200; k++)
         cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
